// File: rtl/pulse_identifier_multi_if.sv
// Solver handshake and result bus for pulse_identifier_multi.
//   master : the pulse identifier (issues solve requests, publishes results)
//   slave  : solver + result consumer
// Signals:
//   solve_start/first_idx/second_idx  -> request to the polynomial/offset solver
//   solve_done/polynomial/offset/ts_first <- solver completion and result
//   ack                               <- consumer has read the results
//   ready/polynomial/pulse_id/id_valid/error -> results and abort pulse
// pulse_id is packed [NUM_SENSORS-1:0][16:0], so sensor k sits at bits [17k+16:17k].
interface pulse_identifier_multi_if #(parameter int NUM_SENSORS = 4);
  logic                             solve_start;
  logic [2:0]                       solve_first_idx;
  logic [2:0]                       solve_second_idx;
  logic                             solve_done;
  logic [16:0]                      solve_polynomial;
  logic [16:0]                      solve_offset;
  logic [23:0]                      solve_ts_first;
  logic                             ack;
  logic                             ready;
  logic [16:0]                      polynomial;
  logic [NUM_SENSORS-1:0][16:0]     pulse_id;
  logic [NUM_SENSORS-1:0]           id_valid;
  logic                             error;

  modport master (
    output solve_start, solve_first_idx, solve_second_idx,
    input  solve_done, solve_polynomial, solve_offset, solve_ts_first,
    input  ack,
    output ready, polynomial, pulse_id, id_valid, error
  );

  modport slave (
    input  solve_start, solve_first_idx, solve_second_idx,
    output solve_done, solve_polynomial, solve_offset, solve_ts_first,
    output ack,
    input  ready, polynomial, pulse_id, id_valid, error
  );
endinterface

// File: rtl/pulse_identifier_multi.sv
// pulse_identifier_multi: timestamps the first arrival on each of NUM_SENSORS
// photodiode channels within a lighthouse sweep, hands the two earliest
// sensors to an external solver, then derives a 17-bit pulse ID for every
// sensor that reported before the timeout. Results are held until ack.
// Ports:
//   clk_72MHz     in   system clock
//   reset         in   synchronous active-high reset
//   avl_nonempty  in   [NUM_SENSORS] per-sensor RAM non-empty flags
//   sys_ts        in   [24] free-running timestamp (wraps)
//   bus           master modport of pulse_identifier_multi_if (solver + results)
// Optional (macro PULSE_ID_ERR_COUNT_EN):
//   err_count      out [16] saturating count of aborted sweeps
//   last_err_state out [4]  state code the most recent abort was entered from
// The interface instance must use the same NUM_SENSORS as this module.

// Per-sensor arrival capture: first-arrival flag and its timestamp.
module pim_lane (
  input  logic        clk_72MHz,
  input  logic        reset,
  input  logic        cap_en,
  input  logic        clr,
  input  logic        avl,
  input  logic [23:0] sys_ts,
  output logic        seen,
  output logic [23:0] ts
);
  always_ff @(posedge clk_72MHz) begin
    if (reset || clr) begin
      seen <= 1'b0;
      ts   <= '0;
    end else if (cap_en && avl && !seen) begin
      seen <= 1'b1;
      ts   <= sys_ts;
    end
  end
endmodule

module pulse_identifier_multi #(
  parameter int NUM_SENSORS   = 4,
  parameter int TIMEOUT_TICKS = 72000,
  parameter int SETTLE_TICKS  = 3750,
  parameter int ITER_SHIFT    = 4
) (
  input  logic                   clk_72MHz,
  input  logic                   reset,
  input  logic [NUM_SENSORS-1:0] avl_nonempty,
  input  logic [23:0]            sys_ts,
  pulse_identifier_multi_if.master bus
`ifdef PULSE_ID_ERR_COUNT_EN
  ,
  output logic [15:0]            err_count,
  output logic [3:0]             last_err_state
`endif
);
  localparam int IW = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam int SW = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_COLLECT    = 4'd1,
    S_SETTLE     = 4'd2,
    S_SOLVE      = 4'd3,
    S_GATHER     = 4'd4,
    S_COMPUTE    = 4'd5,
    S_DATA_READY = 4'd6,
    S_ABORT      = 4'd7,
    S_DRAIN      = 4'd8
  } state_t;

  state_t state, nxt;

  logic [NUM_SENSORS-1:0]       seen;
  logic [NUM_SENSORS-1:0][23:0] ts;
  logic [NUM_SENSORS-1:0]       seen_nx, cand, first_mask;
  logic                         cap_en, lane_clr, to_hit, solve_ok;
  logic [TW-1:0]                to_cnt;
  logic [SW-1:0]                st_cnt;
  logic [IW-1:0]                cmp_idx;
  logic [16:0]                  offset_q;
  logic [23:0]                  ts_first_q;
  logic [23:0]                  delta;
  logic [16:0]                  pid_calc;

  // Lowest set bit; used for both first and second sensor so that
  // simultaneous arrivals resolve by index.
  function automatic logic [2:0] lowest(input logic [NUM_SENSORS-1:0] v);
    lowest = 3'd0;
    for (int i = NUM_SENSORS - 1; i >= 0; i--)
      if (v[i]) lowest = 3'(i);
  endfunction

  // Capture window is COLLECT through GATHER; it freezes once GATHER exits.
  assign cap_en   = (state == S_COLLECT) || (state == S_SETTLE) ||
                    (state == S_SOLVE)   || (state == S_GATHER);
  assign lane_clr = (state == S_DRAIN) && (avl_nonempty == '0);

  for (genvar k = 0; k < NUM_SENSORS; k++) begin : g_lane
    pim_lane u_lane (
      .clk_72MHz (clk_72MHz),
      .reset     (reset),
      .cap_en    (cap_en),
      .clr       (lane_clr),
      .avl       (avl_nonempty[k]),
      .sys_ts    (sys_ts),
      .seen      (seen[k]),
      .ts        (ts[k])
    );
  end

  // Arrivals landing this cycle count toward the second-sensor decision.
  assign seen_nx    = seen | (cap_en ? (avl_nonempty & ~seen) : '0);
  assign first_mask = NUM_SENSORS'(1) << bus.solve_first_idx;
  assign cand       = seen_nx & ~first_mask;
  // Counter saturates at TIMEOUT_TICKS, so >= stays true through SOLVE/GATHER.
  assign to_hit     = (to_cnt >= TW'(TIMEOUT_TICKS));
  assign solve_ok   = (bus.solve_polynomial != '0) && (bus.solve_offset != '0);

  // Shared per-cycle ID datapath; 24-bit subtraction gives the natural wrap.
  assign delta    = ts[cmp_idx] - ts_first_q;
  assign pid_calc = offset_q + 17'(delta >> ITER_SHIFT);

  always_ff @(posedge clk_72MHz) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:       if (|avl_nonempty) nxt = S_COLLECT;
      S_COLLECT:    if (|cand) nxt = S_SETTLE;
                    else if (to_hit) nxt = S_ABORT;
      S_SETTLE:     if (st_cnt == SW'(SETTLE_TICKS - 1)) nxt = S_SOLVE;
      S_SOLVE:      if (bus.solve_done) nxt = solve_ok ? S_GATHER : S_ABORT;
      S_GATHER:     if ((&seen) || to_hit) nxt = S_COMPUTE;
      S_COMPUTE:    if (cmp_idx == IW'(NUM_SENSORS - 1)) nxt = S_DATA_READY;
      S_DATA_READY: if (bus.ack) nxt = S_DRAIN;
      S_ABORT:      nxt = S_DRAIN;
      S_DRAIN:      if (avl_nonempty == '0) nxt = S_IDLE;
      default:      nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_72MHz) begin
    if (reset) begin
      bus.solve_start      <= 1'b0;
      bus.solve_first_idx  <= '0;
      bus.solve_second_idx <= '0;
      bus.ready            <= 1'b0;
      bus.error            <= 1'b0;
      bus.polynomial       <= '0;
      bus.pulse_id         <= '0;
      bus.id_valid         <= '0;
      offset_q             <= '0;
      ts_first_q           <= '0;
      to_cnt               <= '0;
      st_cnt               <= '0;
      cmp_idx              <= '0;
    end else begin
      bus.solve_start <= (state == S_SETTLE) && (nxt == S_SOLVE);
      bus.ready       <= (nxt == S_DATA_READY);
      bus.error       <= (nxt == S_ABORT);
      if (cap_en && !to_hit) to_cnt <= to_cnt + TW'(1);

      case (state)
        S_IDLE: begin
          to_cnt <= '0;
          if (|avl_nonempty) bus.solve_first_idx <= lowest(avl_nonempty);
        end
        S_COLLECT: begin
          st_cnt <= '0;
          if (|cand) bus.solve_second_idx <= lowest(cand);
        end
        S_SETTLE: st_cnt <= st_cnt + SW'(1);
        S_SOLVE: begin
          if (bus.solve_done && solve_ok) begin
            bus.polynomial <= bus.solve_polynomial;
            offset_q       <= bus.solve_offset;
            ts_first_q     <= bus.solve_ts_first;
          end
        end
        S_GATHER: cmp_idx <= '0;
        S_COMPUTE: begin
          bus.pulse_id[cmp_idx] <= seen[cmp_idx] ? pid_calc : 17'd0;
          bus.id_valid[cmp_idx] <= seen[cmp_idx];
          cmp_idx               <= cmp_idx + IW'(1);
        end
        S_DRAIN: begin
          if (avl_nonempty == '0) begin
            to_cnt               <= '0;
            st_cnt               <= '0;
            cmp_idx              <= '0;
            bus.solve_first_idx  <= '0;
            bus.solve_second_idx <= '0;
          end
        end
        default: ;
      endcase

      // Aborted sweeps must not leave a previous sweep's results visible.
      if (nxt == S_ABORT) begin
        bus.pulse_id   <= '0;
        bus.id_valid   <= '0;
        bus.polynomial <= '0;
      end
    end
  end

`ifdef PULSE_ID_ERR_COUNT_EN
  always_ff @(posedge clk_72MHz) begin
    if (reset) begin
      err_count      <= '0;
      last_err_state <= '0;
    end else if (nxt == S_ABORT) begin
      if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      last_err_state <= state;
    end
  end
`endif
endmodule
